// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage RISC-V pipeline. It handles load-use stalls, MDU busy stalls,
// control flushes, EX-stage forwarding selects and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [REG_ADDR_W-1:0] ex_rs1_addr,
  input  logic [REG_ADDR_W-1:0] ex_rs2_addr,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_mem_read_en,
  input  logic                  ex_mdu_start,
  input  logic                  mdu_done,
  input  logic                  ex_branch_taken,
  input  logic                  ex_jump_taken,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic                  mem_reg_write_en,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic                  wb_reg_write_en,
  output logic                  pc_write_enable,
  output logic                  if_id_write_enable,
  output logic                  id_ex_write_enable,
  output logic                  id_ex_bubble_en,
  output logic                  if_id_bubble_en,
  output logic                  ex_mem_bubble_en,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  typedef enum logic [1:0] {RUN, LOAD_STALL, MDU_BUSY} state_t;

  localparam logic [2:0] LOAD_INIT = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state, state_next;
  logic [2:0] load_cnt, load_cnt_next;
  logic       luh, ctl, mdu_wait;

  assign luh = ex_mem_read_en && (ex_rd_addr != '0) &&
               ((ex_rd_addr == id_rs1_addr) || (ex_rd_addr == id_rs2_addr));
  assign ctl      = ex_branch_taken || ex_jump_taken;
  assign mdu_wait = ex_mdu_start && !mdu_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      load_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state    <= state_next;
      load_cnt <= load_cnt_next;
    end
  end

  // Outputs are forced idle while rst is high so a mid-stall reset releases the pipeline at once.
  always_comb begin
    // NOTE: every output gets a default first, so no path through this block can infer a latch.
    state_next         = state;
    load_cnt_next      = load_cnt;
    pc_write_enable    = 1'b1;
    if_id_write_enable = 1'b1;
    id_ex_write_enable = 1'b1;
    id_ex_bubble_en    = 1'b0;
    if_id_bubble_en    = 1'b0;
    ex_mem_bubble_en   = 1'b0;
    if (!rst) begin
      if (ctl) begin
        if_id_bubble_en = 1'b1;
        id_ex_bubble_en = 1'b1;
        state_next      = RUN;
        load_cnt_next   = '0;
      end else if (mdu_wait && (state != LOAD_STALL)) begin
        pc_write_enable    = 1'b0;
        if_id_write_enable = 1'b0;
        id_ex_write_enable = 1'b0;
        ex_mem_bubble_en   = 1'b1;
        state_next         = MDU_BUSY;
      end else if (state == MDU_BUSY) begin
        state_next = RUN;
      end else if (state == LOAD_STALL) begin
        pc_write_enable    = 1'b0;
        if_id_write_enable = 1'b0;
        id_ex_bubble_en    = 1'b1;
        load_cnt_next      = load_cnt - 3'd1;
        if (load_cnt <= 3'd1) state_next = RUN;
      end else if (luh) begin
        pc_write_enable    = 1'b0;
        if_id_write_enable = 1'b0;
        id_ex_bubble_en    = 1'b1;
        if (LOAD_STALL_CYCLES > 1) begin
          state_next    = LOAD_STALL;
          load_cnt_next = LOAD_INIT;
        end
      end
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    if (mem_reg_write_en && (mem_rd_addr != '0) && (mem_rd_addr == rs)) return 2'b10;
    if (wb_reg_write_en && (wb_rd_addr != '0) && (wb_rd_addr == rs))    return 2'b01;
    return 2'b00;
  endfunction

  assign fwd_a_sel = fwd_sel(ex_rs1_addr);
  assign fwd_b_sel = fwd_sel(ex_rs2_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write_enable && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
      if (ctl && (flush_cnt != CNT_MAX))              flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios plus random traffic,
// checked against a remaining-cycles reference model.
module tb_pipeline_hazard_ctrl;
  localparam int AW   = 5;
  localparam int NLS  = 3;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic          rst;
    logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
    logic          mem_read, mdu_start, mdu_done, br, jmp;
    logic [AW-1:0] mem_rd;
    logic          mem_we;
    logic [AW-1:0] wb_rd;
    logic          wb_we;
  } stim_t;

  typedef struct packed {
    logic [5:0] ctrl;
    logic [3:0] fwd;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic ex_mem_read_en, ex_mdu_start, mdu_done, ex_branch_taken, ex_jump_taken;
  logic [AW-1:0] mem_rd_addr, wb_rd_addr;
  logic mem_reg_write_en, wb_reg_write_en;
  logic pc_write_enable, if_id_write_enable, id_ex_write_enable;
  logic id_ex_bubble_en, if_id_bubble_en, ex_mem_bubble_en;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .LOAD_STALL_CYCLES(NLS), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .ex_mem_read_en(ex_mem_read_en), .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done),
    .ex_branch_taken(ex_branch_taken), .ex_jump_taken(ex_jump_taken),
    .mem_rd_addr(mem_rd_addr), .mem_reg_write_en(mem_reg_write_en),
    .wb_rd_addr(wb_rd_addr), .wb_reg_write_en(wb_reg_write_en),
    .pc_write_enable(pc_write_enable), .if_id_write_enable(if_id_write_enable),
    .id_ex_write_enable(id_ex_write_enable), .id_ex_bubble_en(id_ex_bubble_en),
    .if_id_bubble_en(if_id_bubble_en), .ex_mem_bubble_en(ex_mem_bubble_en),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  // Reference model: remaining load-stall cycles, pending MDU release, counters as plain ints.
  int load_left = 0;
  bit in_mdu    = 0;
  int m_stall   = 0;
  int m_flush   = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s = '0;
    return s;
  endfunction

  function automatic logic [1:0] ref_fwd(input stim_t s, input logic [AW-1:0] rs);
    if (s.mem_we && s.mem_rd != 0 && s.mem_rd == rs) return 2'b10;
    if (s.wb_we && s.wb_rd != 0 && s.wb_rd == rs)    return 2'b01;
    return 2'b00;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit pc = 1, ifwe = 1, idwe = 1, idb = 0, ifb = 0, exb = 0;
    bit ctl, mwait, luh;
    @(posedge clk);
    #1;
    rst = s.rst;
    id_rs1_addr = s.id_rs1; id_rs2_addr = s.id_rs2;
    ex_rs1_addr = s.ex_rs1; ex_rs2_addr = s.ex_rs2; ex_rd_addr = s.ex_rd;
    ex_mem_read_en = s.mem_read; ex_mdu_start = s.mdu_start; mdu_done = s.mdu_done;
    ex_branch_taken = s.br; ex_jump_taken = s.jmp;
    mem_rd_addr = s.mem_rd; mem_reg_write_en = s.mem_we;
    wb_rd_addr = s.wb_rd; wb_reg_write_en = s.wb_we;

    if (s.rst) begin
      load_left = 0; in_mdu = 0; m_stall = 0; m_flush = 0;
    end
    e.stall = CW'(m_stall);
    e.flush = CW'(m_flush);
    ctl   = s.br || s.jmp;
    mwait = s.mdu_start && !s.mdu_done;
    luh   = s.mem_read && s.ex_rd != 0 && (s.ex_rd == s.id_rs1 || s.ex_rd == s.id_rs2);
    if (!s.rst) begin
      if (ctl) begin
        ifb = 1; idb = 1; load_left = 0; in_mdu = 0;
      end else if (load_left > 0) begin
        pc = 0; ifwe = 0; idb = 1; load_left--;
      end else if (mwait) begin
        pc = 0; ifwe = 0; idwe = 0; exb = 1; in_mdu = 1;
      end else if (in_mdu) begin
        in_mdu = 0;
      end else if (luh) begin
        pc = 0; ifwe = 0; idb = 1; load_left = NLS - 1;
      end
      if (!pc) m_stall = (m_stall >= CMAX) ? CMAX : m_stall + 1;
      if (ctl) m_flush = (m_flush >= CMAX) ? CMAX : m_flush + 1;
    end
    e.ctrl = {pc, ifwe, idwe, idb, ifb, exb};
    e.fwd  = {ref_fwd(s, s.ex_rs1), ref_fwd(s, s.ex_rs2)};
    sb.push_back(e);
  endtask

  // Monitor: outputs are combinational, so one expected entry is consumed per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ctrl", {pc_write_enable, if_id_write_enable, id_ex_write_enable,
                       id_ex_bubble_en, if_id_bubble_en, ex_mem_bubble_en}, e.ctrl);
        check("fwd", {fwd_a_sel, fwd_b_sel}, e.fwd);
        check("stall_cnt", stall_cnt, e.stall);
        check("flush_cnt", flush_cnt, e.flush);
      end
    end
  end

  task automatic do_reset();
    stim_t s = idle();
    s.rst = 1;
    apply(s);
    apply(s);
  endtask

  initial begin
    stim_t s;
    rst = 1'b1;
    {id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr} = '0;
    {ex_mem_read_en, ex_mdu_start, mdu_done, ex_branch_taken, ex_jump_taken} = '0;
    {mem_rd_addr, wb_rd_addr, mem_reg_write_en, wb_reg_write_en} = '0;

    do_reset();
    repeat (2) apply(idle());

    // Load-use on rs2 for one cycle, then idle long enough to see the full stall.
    s = idle(); s.mem_read = 1; s.ex_rd = 5; s.id_rs2 = 5;
    apply(s);
    repeat (4) apply(idle());
    s.ex_rd = 0;
    apply(s);
    repeat (2) apply(idle());

    // MDU busy for 4 cycles, done on the 5th; then start+done together.
    do_reset();
    s = idle(); s.mdu_start = 1;
    repeat (4) apply(s);
    s.mdu_done = 1;
    apply(s);
    apply(idle());
    apply(s);
    apply(idle());

    // Jump in the second cycle of a load stall.
    s = idle(); s.mem_read = 1; s.ex_rd = 9; s.id_rs1 = 9;
    apply(s);
    s = idle(); s.jmp = 1;
    apply(s);
    repeat (2) apply(idle());

    // Forwarding priority and the x0 exclusion.
    s = idle(); s.ex_rs1 = 7; s.ex_rs2 = 7; s.mem_rd = 7; s.wb_rd = 7; s.mem_we = 1; s.wb_we = 1;
    apply(s);
    s.mem_we = 0;
    apply(s);
    s.wb_rd = 0;
    apply(s);

    // Long MDU stall to saturate stall_cnt, then reset while the stall is still requested.
    do_reset();
    s = idle(); s.mdu_start = 1;
    repeat (20) apply(s);
    s.rst = 1;
    apply(s);
    s.rst = 0;
    apply(s);
    s.mdu_done = 1;
    apply(s);

    // Random traffic with small register numbers so hazards collide often.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      s = idle();
      s.rst       = ($urandom_range(0, 79) == 0);
      s.id_rs1    = AW'($urandom_range(0, 3));
      s.id_rs2    = AW'($urandom_range(0, 3));
      s.ex_rs1    = AW'($urandom_range(0, 3));
      s.ex_rs2    = AW'($urandom_range(0, 3));
      s.ex_rd     = AW'($urandom_range(0, 3));
      s.mem_rd    = AW'($urandom_range(0, 3));
      s.wb_rd     = AW'($urandom_range(0, 3));
      s.mem_read  = $urandom_range(0, 1) == 1;
      s.mem_we    = $urandom_range(0, 1) == 1;
      s.wb_we     = $urandom_range(0, 1) == 1;
      s.mdu_start = ($urandom_range(0, 4) == 0);
      s.mdu_done  = ($urandom_range(0, 2) == 0);
      s.br        = ($urandom_range(0, 9) == 0);
      s.jmp       = ($urandom_range(0, 14) == 0);
      apply(s);
    end
    apply(idle());

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries left unchecked", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Next-generation hazard controller for the 5-stage RISC-V pipeline. It adds configurable multi-cycle load-use stalls, a stall FSM for a multi-cycle multiply/divide unit (MDU) in EX, EX-stage forwarding-select generation, and saturating stall/flush performance counters. It sits beside the pipeline registers and drives PC/IF-ID write enables, stage bubbles and the EX operand muxes.

Parameters:
REG_ADDR_W, 5, register address width
LOAD_STALL_CYCLES, 1, stall cycles per load-use hazard; legal range 1..7
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
id_rs1_addr  in  REG_ADDR_W  rs1 address of the instruction in ID
id_rs2_addr  in  REG_ADDR_W  rs2 address of the instruction in ID
ex_rs1_addr  in  REG_ADDR_W  rs1 address of the instruction in EX
ex_rs2_addr  in  REG_ADDR_W  rs2 address of the instruction in EX
ex_rd_addr  in  REG_ADDR_W  destination register of the instruction in EX
ex_mem_read_en  in  1  the instruction in EX is a load
ex_mdu_start  in  1  an MDU op is in EX
mdu_done  in  1  MDU result is valid this cycle
ex_branch_taken  in  1  a branch resolved taken in EX
ex_jump_taken  in  1  a jump is in EX
mem_rd_addr  in  REG_ADDR_W  EX/MEM destination register
mem_reg_write_en  in  1  EX/MEM writes the register file
wb_rd_addr  in  REG_ADDR_W  MEM/WB destination register
wb_reg_write_en  in  1  MEM/WB writes the register file
pc_write_enable  out  1  PC may update
if_id_write_enable  out  1  IF/ID may load
id_ex_write_enable  out  1  ID/EX may load
id_ex_bubble_en  out  1  load a NOP into ID/EX
if_id_bubble_en  out  1  load a NOP into IF/ID
ex_mem_bubble_en  out  1  load a NOP into EX/MEM
fwd_a_sel  out  2  EX operand A source: 00 = register file, 01 = MEM/WB, 10 = EX/MEM
fwd_b_sel  out  2  EX operand B source, same encoding
stall_cnt  out  CNT_W  cycles with pc_write_enable = 0, saturating
flush_cnt  out  CNT_W  cycles with a control flush, saturating

Behaviour:
- Reset is asynchronous and active-high. On reset: state = RUN, load counter = 0, stall_cnt = 0, flush_cnt = 0.
- All outputs are combinational from the current state and inputs. With idle inputs, the outputs are: pc_write_enable = 1, if_id_write_enable = 1, id_ex_write_enable = 1, all bubble outputs = 0, fwd_a_sel = 00, fwd_b_sel = 00.
- luh (load-use hazard) = ex_mem_read_en && ex_rd_addr != 0 && (ex_rd_addr == id_rs1_addr || ex_rd_addr == id_rs2_addr).
- ctl (control hazard) = ex_branch_taken || ex_jump_taken.
- mdu_wait = ex_mdu_start && !mdu_done.
- Evaluation priority, highest first: ctl, then MDU wait, then load stall.
- ctl:
  - if_id_bubble_en = 1, id_ex_bubble_en = 1; PC and IF/ID write enables = 1.
  - Next state = RUN and the load counter is cleared. A flush cancels any pending stall.
- MDU wait, in RUN or MDU_BUSY with mdu_wait = 1:
  - pc_write_enable = 0, if_id_write_enable = 0, id_ex_write_enable = 0, ex_mem_bubble_en = 1.
  - Next state = MDU_BUSY.
- MDU release: when mdu_done = 1, no stall is asserted and next state = RUN. If mdu_done = 1 in the same cycle as ex_mdu_start, there are zero stall cycles.
- Load stall, state RUN with luh = 1:
  - pc_write_enable = 0, if_id_write_enable = 0, id_ex_bubble_en = 1.
  - If LOAD_STALL_CYCLES > 1: next state = LOAD_STALL and load counter = LOAD_STALL_CYCLES - 1.
- LOAD_STALL state:
  - Same stall outputs as a load stall; luh is not re-evaluated.
  - Counter decrements each cycle; on the cycle it reaches 1, next state = RUN.
  - Total stall per hazard = LOAD_STALL_CYCLES cycles.
- Forwarding, independent of the FSM:
  - fwd_a_sel = 10 if mem_reg_write_en && mem_rd_addr != 0 && mem_rd_addr == ex_rs1_addr.
  - Otherwise 01 if wb_reg_write_en && wb_rd_addr != 0 && wb_rd_addr == ex_rs1_addr.
  - Otherwise 00. fwd_b_sel uses ex_rs2_addr with the same rules. EX/MEM wins over MEM/WB.
- Counters:
  - stall_cnt increments each cycle pc_write_enable = 0.
  - flush_cnt increments each cycle ctl = 1.
  - Both saturate at all-ones and never wrap.
- Reset asserted mid-stall returns to RUN immediately and releases the stall outputs in the same cycle.

Test Plan:
- Reset then idle inputs -> pc_write_enable = 1, all bubbles = 0, fwd = 00, stall_cnt = 0, flush_cnt = 0.
- LOAD_STALL_CYCLES = 3, load ex_rd_addr = 5 with id_rs2_addr = 5 for one cycle -> pc_write_enable = 0 and id_ex_bubble_en = 1 for exactly 3 cycles; stall_cnt = 3. Repeat with ex_rd_addr = 0 -> no stall.
- ex_mdu_start = 1, mdu_done rises 4 cycles later -> 4 cycles of id_ex_write_enable = 0 and ex_mem_bubble_en = 1, release on the done cycle. ex_mdu_start and mdu_done both = 1 in one cycle -> no stall.
- ex_jump_taken = 1 in the 2nd cycle of a 3-cycle load stall -> if_id_bubble_en = 1 and id_ex_bubble_en = 1 that cycle; next cycle is RUN with pc_write_enable = 1; flush_cnt = 1.
- mem_rd_addr = 7 and wb_rd_addr = 7, both write-enabled, ex_rs1_addr = 7 -> fwd_a_sel = 10. Clear mem_reg_write_en -> fwd_a_sel = 01. Set rd = 0 -> fwd_a_sel = 00.
- CNT_W = 4, hold an MDU stall for 20 cycles -> stall_cnt saturates at 15. Assert rst mid-stall -> stall outputs drop immediately and counters = 0.
